cp0_reg_file: RTL and testbench
===============================

// Module: cp0_reg_file
// PURPOSE
//   Coprocessor-0 register file sitting directly downstream of the CP0 control decoder.
//   Consumes its mfc0/mtc0/wsta/wcau/wepc/exception/cause strobes.
//   Holds Status(12), Cause(13), EPC(14), Count(9), Compare(11).
//   Performs exception entry (Status shift, Cause/EPC capture) and ERET return.
//   Supplies the fetch stage with the redirect target.
//   Adds a Count/Compare timer interrupt.
// PARAMETERS
//   EXC_VECTOR  32'h0000_0004  exception handler entry address driven on exc_addr
//   COUNT_DIV   1              Count increments once every COUNT_DIV clk cycles (>=1)
// PORTS
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   mfc0       in   1   read strobe from decoder
//   mtc0       in   1   write strobe from decoder
//   wsta       in   1   Status write enable (mtc0/ERET/exception)
//   wcau       in   1   Cause write enable (mtc0/exception)
//   wepc       in   1   EPC write enable (mtc0/exception)
//   exception  in   1   take exception this cycle
//   eret       in   1   ERET executing this cycle
//   addr       in   5   CP0 register number (rd field)
//   wdata      in   32  GPR rt value for mtc0
//   pc         in   32  PC of the faulting instruction
//   cause_in   in   32  cause code from decoder (ExcCode in [6:2])
//   rdata      out  32  mfc0 read data
//   status     out  32  current Status register
//   exc_addr   out  32  redirect target: EXC_VECTOR on exception, EPC on eret
//   redirect   out  1   fetch must load exc_addr next edge
//   timer_irq  out  1   Cause.IP7 (bit 15) pending
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - Status, Cause, EPC, Count, Compare, and the divider all clear to 0.
//     - rdata=0, redirect=0, timer_irq=0.
//   Reads (combinational, no clk latency):
//     - rdata = reg[addr] when mfc0, else 0.
//     - Unimplemented addr reads 0.
//   Writes occur on the rising clk edge. Priority per register: exception > eret > mtc0.
//   Exception (exception=1):
//     - Status <= {Status[26:0], 5'b0}.
//     - Cause[6:2] <= cause_in[6:2]; Cause[15] is kept.
//     - EPC <= pc.
//     - redirect=1 and exc_addr=EXC_VECTOR, both combinational in the same cycle.
//   ERET (eret=1, exception=0):
//     - Status <= {5'b0, Status[31:5]}.
//     - redirect=1, exc_addr=EPC (value before the edge).
//   mtc0 (no exception/eret):
//     - Status is written when wsta && addr==12.
//     - Cause: only bits [9:8] (software IP) are writable, when wcau && addr==13.
//     - EPC is written when wepc && addr==14.
//     - Count is written at addr==9; Compare at addr==11.
//     - Other addresses are ignored.
//   Count/Compare run independently of exception/eret:
//     - Count increments by 1 when the divider reaches COUNT_DIV-1; the divider then returns to 0.
//     - Count wraps 32'hFFFF_FFFF -> 0.
//     - An mtc0 to Count in the same cycle as a tick wins; the tick is dropped.
//     - Cause[15] sets on the edge after Count==Compare, and only when Compare!=0.
//     - Cause[15] is sticky; it clears only on an mtc0 to Compare.
//     - If that clear coincides with a match, the clear wins.
//   timer_irq = Cause[15] & Status[15] & Status[0].
//     - The core raises the exception; this block only flags the interrupt.
//   Idle: redirect=0 and exc_addr=EPC.
//   Reset mid-operation aborts any write; there is no partial update.
// TESTING
//   1. Reset:
//      - Stimulus: rst_n low mid-cycle, then release.
//      - Required: all registers read 0 via mfc0; redirect=0; timer_irq=0.
//   2. Write/read Status:
//      - Stimulus: mtc0 addr=12 wdata=32'h0000_8001.
//      - Required: next cycle, mfc0 addr=12 returns 32'h0000_8001; status matches.
//   3. Exception entry:
//      - Stimulus: Status=32'h1F, pc=32'h0040_0010, cause_in=32'h20, exception=1.
//      - Required: redirect=1 and exc_addr=32'h4 in the same cycle.
//      - Required after the edge: Status=32'h3E0, EPC=32'h0040_0010, Cause[6:2]=5'b01000.
//   4. Exception + mtc0 same cycle:
//      - Stimulus: mtc0 addr=14 wdata=32'hDEAD and exception=1, pc=32'h100.
//      - Required: EPC=32'h100.
//      - Required for ERET afterwards: Status shifts back to 32'h1F; exc_addr=32'h100.
//   5. Timer:
//      - Stimulus: COUNT_DIV=1; Compare=5; Count=0; Status=32'h8001.
//      - Required: Cause[15] and timer_irq rise on the edge after Count==5.
//      - Required: writing Compare=9 clears them.
//      - Stimulus: Count=32'hFFFF_FFFF. Required: wraps to 0 next edge.

Source files
------------

// File: rtl/cp0_reg_file.sv
// -----------------------------------------------------------------------------
// cp0_reg_file
//   Coprocessor-0 register file fed by the CP0 control decoder. Holds Status(12),
//   Cause(13), EPC(14), Count(9) and Compare(11). Performs exception entry
//   (Status shift left by 5, Cause.ExcCode and EPC capture) and ERET return
//   (Status shift right by 5), drives the fetch redirect target, and raises a
//   Count/Compare timer interrupt flag on Cause.IP7.
//
//   Ports
//     clk, rst_n            clock (rising edge), async active-low reset
//     mfc0, mtc0            read / write strobes from the decoder
//     wsta, wcau, wepc      per-register write enables for mtc0
//     exception, eret       exception entry / ERET this cycle
//     addr                  CP0 register number
//     wdata                 mtc0 write data
//     pc                    PC of the faulting instruction (captured to EPC)
//     cause_in              ExcCode source, bits [6:2]
//     rdata                 combinational mfc0 read data (0 when mfc0 low)
//     status                current Status register
//     exc_addr              EXC_VECTOR on exception, otherwise EPC
//     redirect              fetch loads exc_addr on the next edge
//     timer_irq             Cause[15] & Status[15] & Status[0]
//
//   Write priority per register: exception > eret > mtc0. Count ticking and the
//   Cause[15] timer flag are independent of exception/eret.
// -----------------------------------------------------------------------------
module cp0_reg_file #(
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0004,
   parameter int unsigned COUNT_DIV  = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mfc0,
   input  logic        mtc0,
   input  logic        wsta,
   input  logic        wcau,
   input  logic        wepc,
   input  logic        exception,
   input  logic        eret,
   input  logic [4:0]  addr,
   input  logic [31:0] wdata,
   input  logic [31:0] pc,
   input  logic [31:0] cause_in,
   output logic [31:0] rdata,
   output logic [31:0] status,
   output logic [31:0] exc_addr,
   output logic        redirect,
   output logic        timer_irq
);

   localparam logic [4:0] A_COUNT   = 5'd9;
   localparam logic [4:0] A_COMPARE = 5'd11;
   localparam logic [4:0] A_STATUS  = 5'd12;
   localparam logic [4:0] A_CAUSE   = 5'd13;
   localparam logic [4:0] A_EPC     = 5'd14;

   // Divider needs at least one bit even when COUNT_DIV is 1.
   localparam int DW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(COUNT_DIV - 1);

   logic [31:0]   status_q;
   logic [31:0]   cause_q;
   logic [31:0]   epc_q;
   logic [31:0]   count_q;
   logic [31:0]   compare_q;
   logic [DW-1:0] div_q;

   // Only ExcCode bits of cause_in are consumed.
   logic unused_cause_bits;
   assign unused_cause_bits = ^{cause_in[31:7], cause_in[1:0]};

   // An mtc0 only lands when no exception or eret owns this cycle.
   logic mtc0_ok;
   logic wr_status, wr_cause, wr_epc, wr_count, wr_compare;
   logic tick, match;

   assign mtc0_ok    = mtc0 & ~exception & ~eret;
   assign wr_status  = mtc0_ok & wsta & (addr == A_STATUS);
   assign wr_cause   = mtc0_ok & wcau & (addr == A_CAUSE);
   assign wr_epc     = mtc0_ok & wepc & (addr == A_EPC);
   assign wr_count   = mtc0_ok & (addr == A_COUNT);
   assign wr_compare = mtc0_ok & (addr == A_COMPARE);

   assign tick  = (div_q == DIV_LAST);
   // Compare==0 means the timer is disarmed.
   assign match = (count_q == compare_q) && (compare_q != 32'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         status_q  <= 32'd0;
         cause_q   <= 32'd0;
         epc_q     <= 32'd0;
         count_q   <= 32'd0;
         compare_q <= 32'd0;
         div_q     <= '0;
      end else begin
         // Status
         if (exception) begin
            status_q <= {status_q[26:0], 5'b0};
         end else if (eret) begin
            status_q <= {5'b0, status_q[31:5]};
         end else if (wr_status) begin
            status_q <= wdata;
         end

         // EPC
         if (exception) begin
            epc_q <= pc;
         end else if (wr_epc) begin
            epc_q <= wdata;
         end

         // Cause: ExcCode from exception, software IP from mtc0 only.
         if (exception) begin
            cause_q[6:2] <= cause_in[6:2];
         end else if (wr_cause) begin
            cause_q[9:8] <= wdata[9:8];
         end

         // Cause.IP7 is sticky; a Compare write clears it and beats a match.
         if (wr_compare) begin
            cause_q[15] <= 1'b0;
         end else if (match) begin
            cause_q[15] <= 1'b1;
         end

         // Count: software write wins over a tick on the same edge.
         if (wr_count) begin
            count_q <= wdata;
         end else if (tick) begin
            count_q <= count_q + 32'd1;
         end

         if (tick) begin
            div_q <= '0;
         end else begin
            div_q <= div_q + 1'b1;
         end

         if (wr_compare) begin
            compare_q <= wdata;
         end
      end
   end

   always_comb begin
      rdata = 32'd0;
      if (mfc0) begin
         case (addr)
            A_COUNT:   rdata = count_q;
            A_COMPARE: rdata = compare_q;
            A_STATUS:  rdata = status_q;
            A_CAUSE:   rdata = cause_q;
            A_EPC:     rdata = epc_q;
            default:   rdata = 32'd0;
         endcase
      end
   end

   assign status    = status_q;
   assign redirect  = exception | eret;
   assign exc_addr  = exception ? EXC_VECTOR : epc_q;
   assign timer_irq = cause_q[15] & status_q[15] & status_q[0];

endmodule

// File: tb/tb_cp0_reg_file.sv
// -----------------------------------------------------------------------------
// tb_cp0_reg_file
//   Directed table, hand-written timer/reset sequences and randomized traffic
//   for cp0_reg_file. A register-array reference model tracks the CP0 state and
//   predicts every combinational output each cycle.
// -----------------------------------------------------------------------------
module tb_cp0_reg_file;

   localparam int unsigned COUNT_DIV = 1;

   typedef struct {
      logic        mfc0;
      logic        mtc0;
      logic        wsta;
      logic        wcau;
      logic        wepc;
      logic        exception;
      logic        eret;
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic [31:0] pc;
      logic [31:0] cause_in;
   } in_t;

   typedef struct {
      in_t         in;
      logic [31:0] exp_rdata;
      logic        exp_redirect;
      logic [31:0] exp_exc_addr;
      logic [31:0] exp_status;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   in_t         cur;
   logic [31:0] rdata, status, exc_addr;
   logic        redirect, timer_irq;

   int checks = 0;
   int errors = 0;

   // reference model state: CP0 registers indexed by register number
   logic [31:0] m [0:31];
   int unsigned mcyc;

   cp0_reg_file #(.EXC_VECTOR(32'h0000_0004), .COUNT_DIV(COUNT_DIV)) dut (
      .clk(clk), .rst_n(rst_n),
      .mfc0(cur.mfc0), .mtc0(cur.mtc0), .wsta(cur.wsta), .wcau(cur.wcau),
      .wepc(cur.wepc), .exception(cur.exception), .eret(cur.eret),
      .addr(cur.addr), .wdata(cur.wdata), .pc(cur.pc), .cause_in(cur.cause_in),
      .rdata(rdata), .status(status), .exc_addr(exc_addr),
      .redirect(redirect), .timer_irq(timer_irq)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic in_t idle_in();
      in_t r;
      r = '{default: '0};
      return r;
   endfunction

   function automatic in_t rd(input logic [4:0] a);
      in_t r;
      r = idle_in();
      r.mfc0 = 1'b1;
      r.addr = a;
      return r;
   endfunction

   function automatic in_t wr(input logic [4:0] a, input logic [31:0] d);
      in_t r;
      r = idle_in();
      r.mtc0 = 1'b1;
      r.wsta = 1'b1;
      r.wcau = 1'b1;
      r.wepc = 1'b1;
      r.addr = a;
      r.wdata = d;
      return r;
   endfunction

   function automatic vec_t v(input logic mf, input logic mt, input logic ws, input logic wc,
                              input logic we, input logic ex, input logic er,
                              input logic [4:0] a, input logic [31:0] wd, input logic [31:0] p,
                              input logic [31:0] ci, input logic [31:0] e_rd, input logic e_rr,
                              input logic [31:0] e_ea, input logic [31:0] e_st);
      vec_t r;
      r.in = '{mf, mt, ws, wc, we, ex, er, a, wd, p, ci};
      r.exp_rdata = e_rd;
      r.exp_redirect = e_rr;
      r.exp_exc_addr = e_ea;
      r.exp_status = e_st;
      return r;
   endfunction

   function automatic bit implemented(input logic [4:0] a);
      return (a == 5'd9) || (a == 5'd11) || (a == 5'd12) || (a == 5'd13) || (a == 5'd14);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m[i] = 32'd0;
      mcyc = 0;
   endtask

   // Predict outputs for the current inputs and compare, away from the edge.
   task automatic tick_check();
      logic [31:0] e_rdata;
      @(negedge clk);
      e_rdata = (cur.mfc0 && implemented(cur.addr)) ? m[cur.addr] : 32'd0;
      chk("rdata", rdata, e_rdata);
      chk("status", status, m[12]);
      chk("redirect", {31'd0, redirect}, {31'd0, cur.exception | cur.eret});
      chk("exc_addr", exc_addr, cur.exception ? 32'h0000_0004 : m[14]);
      chk("timer_irq", {31'd0, timer_irq}, {31'd0, m[13][15] & m[12][15] & m[12][0]});
   endtask

   // Apply the register rules to the model, then let the edge happen.
   task automatic tick_edge();
      logic [31:0] n [0:31];
      bit count_written, compare_written;
      n = m;
      count_written = 0;
      compare_written = 0;
      if (cur.exception) begin
         n[12] = m[12] << 5;
         n[13][6:2] = cur.cause_in[6:2];
         n[14] = cur.pc;
      end else if (cur.eret) begin
         n[12] = m[12] >> 5;
      end else if (cur.mtc0) begin
         case (cur.addr)
            5'd12: if (cur.wsta) n[12] = cur.wdata;
            5'd13: if (cur.wcau) n[13][9:8] = cur.wdata[9:8];
            5'd14: if (cur.wepc) n[14] = cur.wdata;
            5'd9:  begin n[9] = cur.wdata; count_written = 1; end
            5'd11: begin n[11] = cur.wdata; compare_written = 1; end
            default: ;
         endcase
      end
      if ((mcyc % COUNT_DIV) == COUNT_DIV - 1 && !count_written) n[9] = m[9] + 32'd1;
      if (compare_written) n[13][15] = 1'b0;
      else if (m[9] == m[11] && m[11] != 0) n[13][15] = 1'b1;
      @(posedge clk);
      m = n;
      mcyc++;
      #1;
   endtask

   task automatic cyc(input in_t x);
      cur = x;
      tick_check();
      tick_edge();
   endtask

   // Reset asserted mid-cycle with whatever inputs are applied; released after an edge.
   task automatic do_reset(input in_t x);
      cur = x;
      #3 rst_n = 1'b0;
      #1;
      chk("rst_status", status, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_timer_irq", {31'd0, timer_irq}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
      cur = idle_in();
   endtask

   task automatic reset_reads();
      logic [4:0] regs [5];
      regs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14};
      for (int i = 0; i < 5; i++) begin
         cur = rd(regs[i]);
         tick_check();
         chk("post_reset_reg", rdata, 32'd0);
         chk("post_reset_redirect", {31'd0, redirect}, 32'd0);
         tick_edge();
      end
   endtask

   function automatic in_t rand_in();
      in_t r;
      r.exception = ($urandom_range(0, 19) == 0);
      r.eret = !r.exception && ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 5))
         0: r.addr = 5'd9;
         1: r.addr = 5'd11;
         2: r.addr = 5'd12;
         3: r.addr = 5'd13;
         4: r.addr = 5'd14;
         default: r.addr = 5'($urandom_range(0, 31));
      endcase
      r.mfc0 = $urandom_range(0, 1) == 1;
      r.mtc0 = $urandom_range(0, 2) == 0;
      if ((r.exception || r.eret) && (r.addr == 5'd9 || r.addr == 5'd11)) r.mtc0 = 1'b0;
      r.wsta = $urandom_range(0, 1) == 1;
      r.wcau = $urandom_range(0, 1) == 1;
      r.wepc = $urandom_range(0, 1) == 1;
      r.wdata = (r.addr == 5'd9 || r.addr == 5'd11) ? 32'($urandom_range(0, 24)) : $urandom;
      r.pc = $urandom;
      r.cause_in = $urandom;
      return r;
   endfunction

   // ---------------- test ----------------
   vec_t tbl [18];
   in_t  x;

   initial begin
      cur = idle_in();
      model_reset();

      // 1. reset
      do_reset(rd(5'd12));
      reset_reads();

      // 2-4. directed table
      tbl[0]  = v(0,1,1,0,0,0,0,12,32'h8001,0,0,         0,0,32'h0,32'h0);
      tbl[1]  = v(1,0,0,0,0,0,0,12,0,0,0,                32'h8001,0,32'h0,32'h8001);
      tbl[2]  = v(0,1,1,0,0,0,0,12,32'h1F,0,0,           0,0,32'h0,32'h8001);
      tbl[3]  = v(1,0,0,0,0,1,0,12,0,32'h0040_0010,32'h20, 32'h1F,1,32'h4,32'h1F);
      tbl[4]  = v(1,0,0,0,0,0,0,12,0,0,0,                32'h3E0,0,32'h0040_0010,32'h3E0);
      tbl[5]  = v(1,0,0,0,0,0,0,14,0,0,0,                32'h0040_0010,0,32'h0040_0010,32'h3E0);
      tbl[6]  = v(1,0,0,0,0,0,0,13,0,0,0,                32'h20,0,32'h0040_0010,32'h3E0);
      tbl[7]  = v(0,1,1,0,0,0,0,12,32'h1F,0,0,           0,0,32'h0040_0010,32'h3E0);
      tbl[8]  = v(0,1,0,0,1,1,0,14,32'hDEAD,32'h100,0,   0,1,32'h4,32'h1F);
      tbl[9]  = v(1,0,0,0,0,0,0,14,0,0,0,                32'h100,0,32'h100,32'h3E0);
      tbl[10] = v(1,0,0,0,0,0,1,12,0,0,0,                32'h3E0,1,32'h100,32'h3E0);
      tbl[11] = v(1,0,0,0,0,0,0,12,0,0,0,                32'h1F,0,32'h100,32'h1F);
      tbl[12] = v(0,1,0,1,0,0,0,13,32'hFFFF_FFFF,0,0,    0,0,32'h100,32'h1F);
      tbl[13] = v(1,0,0,0,0,0,0,13,0,0,0,                32'h300,0,32'h100,32'h1F);
      tbl[14] = v(0,1,1,0,0,0,1,12,32'hAAAA,0,0,         0,1,32'h100,32'h1F);
      tbl[15] = v(1,0,0,0,0,0,0,12,0,0,0,                0,0,32'h100,32'h0);
      tbl[16] = v(0,1,1,1,1,0,0,20,32'h1234,0,0,         0,0,32'h100,32'h0);
      tbl[17] = v(1,0,0,0,0,0,0,20,0,0,0,                0,0,32'h100,32'h0);
      for (int i = 0; i < 18; i++) begin
         cur = tbl[i].in;
         tick_check();
         chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp_rdata);
         chk($sformatf("tbl%0d_redirect", i), {31'd0, redirect}, {31'd0, tbl[i].exp_redirect});
         chk($sformatf("tbl%0d_exc_addr", i), exc_addr, tbl[i].exp_exc_addr);
         chk($sformatf("tbl%0d_status", i), status, tbl[i].exp_status);
         tick_edge();
      end

      // 5. timer: Status=8001, Compare=5, Count=0
      cyc(wr(5'd12, 32'h8001));
      cyc(wr(5'd11, 32'd5));
      cyc(wr(5'd9, 32'd0));
      for (int i = 0; i < 5; i++) cyc(idle_in());
      cur = idle_in();            // Count==5 during this cycle
      tick_check();
      chk("timer_before_match_edge", {31'd0, timer_irq}, 32'd0);
      tick_edge();
      cur = rd(5'd13);
      tick_check();
      chk("timer_irq_set", {31'd0, timer_irq}, 32'd1);
      chk("cause15_set", {31'd0, rdata[15]}, 32'd1);
      tick_edge();
      cyc(wr(5'd11, 32'd9));
      cur = rd(5'd13);
      tick_check();
      chk("cause15_cleared", {31'd0, rdata[15]}, 32'd0);
      chk("timer_irq_cleared", {31'd0, timer_irq}, 32'd0);
      tick_edge();

      // Count wrap
      cyc(wr(5'd9, 32'hFFFF_FFFF));
      cur = rd(5'd9);
      tick_check();
      chk("count_max", rdata, 32'hFFFF_FFFF);
      tick_edge();
      cur = rd(5'd9);
      tick_check();
      chk("count_wrap", rdata, 32'd0);
      tick_edge();

      // Compare write coinciding with a match: clear wins
      cyc(wr(5'd9, 32'd100));
      cyc(wr(5'd11, 32'd9));
      cyc(wr(5'd9, 32'd9));
      cyc(wr(5'd11, 32'd9));      // Count==Compare==9 this cycle
      cur = rd(5'd13);
      tick_check();
      chk("clear_beats_match", {31'd0, rdata[15]}, 32'd0);
      tick_edge();

      // Tick dropped when Count is written on the same edge
      cyc(wr(5'd9, 32'd40));
      cur = rd(5'd9);
      tick_check();
      chk("count_write_wins", rdata, 32'd40);
      tick_edge();

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) cyc(rand_in());

      // reset mid-operation with an mtc0 pending
      cyc(wr(5'd12, 32'h8001));
      x = wr(5'd12, 32'h5555);
      x.mfc0 = 1'b1;
      do_reset(x);
      reset_reads();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute guard so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
